display_bcd_scheduler: RTL and testbench

- Sequential, shared binary-to-BCD conversion engine and display-source scheduler for the eight-digit seven-segment front end.
- Arbitrates between two requesters, the IO value path and the PC path, and runs one iterative double-dabble conversion at a time.
- Holds a committed BCD result per source and selects which result drives the digit decoders, including a hold-off timer after IO activity ends.
- Sits between the CPU (IO_output, negative, PC_current, FLAG_input, FLAG_output) and the segment decoders.

---
 rtl/display_bcd_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_display_bcd_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/display_bcd_scheduler.sv
// Shared double-dabble binary-to-BCD engine that serves the IO value path and the PC path,
// plus the registered display-source selection (with IO hold-off) that feeds the digit decoders.
module display_bcd_scheduler #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOLD_W      = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IO_output,
  input  logic        negative,
  input  logic [31:0] PC_current,
  input  logic        FLAG_input,
  input  logic        FLAG_output,
  output logic [31:0] bcd_digits,
  output logic        show_io,
  output logic        neg_out,
  output logic        overflow,
  output logic        busy,
  output logic        result_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic [31:0]        shift_q, shift_d;
  logic [39:0]        acc_q, acc_d;
  logic               grant_io_q, grant_io_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        io_snap_q, io_snap_d;
  logic               neg_snap_q, neg_snap_d;
  logic [31:0]        pc_snap_q, pc_snap_d;
  logic               io_seen_q, io_seen_d;
  logic               pc_seen_q, pc_seen_d;
  logic [31:0]        io_bcd_q, io_bcd_d;
  logic               io_ovf_q, io_ovf_d;
  logic               io_neg_q, io_neg_d;
  logic [31:0]        pc_bcd_q, pc_bcd_d;
  logic               pc_ovf_q, pc_ovf_d;
  logic               result_valid_q, result_valid_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               show_io_q, show_io_d;
  logic [31:0]        bcd_digits_q, bcd_digits_d;
  logic               overflow_q, overflow_d;
  logic               neg_out_q, neg_out_d;

  logic               flag_any;
  logic               io_req;
  logic               pc_req;
  logic               pick_io;
  logic [39:0]        acc_adj;

  // last_grant_q / grant_io_q: 1 means the IO source, 0 means the PC source.
  function automatic logic [39:0] add3_digits(input logic [39:0] a);
    logic [39:0] r;
    r = a;
    for (int i = 0; i < 10; i++) begin
      if (a[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign flag_any = FLAG_input | FLAG_output;
  assign io_req   = flag_any & (~io_seen_q | (IO_output != io_snap_q) | (negative != neg_snap_q));
  assign pc_req   = (PC_current != pc_snap_q) | ~pc_seen_q;

  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    shift_d        = shift_q;
    acc_d          = acc_q;
    grant_io_d     = grant_io_q;
    last_grant_d   = last_grant_q;
    io_snap_d      = io_snap_q;
    neg_snap_d     = neg_snap_q;
    pc_snap_d      = pc_snap_q;
    io_seen_d      = io_seen_q;
    pc_seen_d      = pc_seen_q;
    io_bcd_d       = io_bcd_q;
    io_ovf_d       = io_ovf_q;
    io_neg_d       = io_neg_q;
    pc_bcd_d       = pc_bcd_q;
    pc_ovf_d       = pc_ovf_q;
    result_valid_d = 1'b0;
    pick_io        = 1'b0;
    acc_adj        = add3_digits(acc_q);

    case (state_q)
      ST_IDLE: begin
        if (io_req | pc_req) begin
          // With both pending, the source that did not win last time goes first.
          pick_io      = io_req & (~pc_req | ~last_grant_q);
          grant_io_d   = pick_io;
          last_grant_d = pick_io;
          acc_d        = '0;
          iter_d       = '0;
          state_d      = ST_SHIFT;
          if (pick_io) begin
            shift_d    = IO_output;
            io_snap_d  = IO_output;
            neg_snap_d = negative;
          end else begin
            shift_d    = PC_current;
            pc_snap_d  = PC_current;
          end
        end
      end

      ST_SHIFT: begin
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) state_d = ST_DONE;
      end

      ST_DONE: begin
        if (grant_io_q) begin
          io_bcd_d  = acc_q[31:0];
          io_ovf_d  = (acc_q[39:32] != 8'd0);
          io_neg_d  = neg_snap_q;
          io_seen_d = 1'b1;
        end else begin
          pc_bcd_d  = acc_q[31:0];
          pc_ovf_d  = (acc_q[39:32] != 8'd0);
          pc_seen_d = 1'b1;
        end
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // show_io tracks io_seen_q, so the IO view can never surface before an IO result exists.
  always_comb begin
    hold_d    = hold_q;
    show_io_d = show_io_q;
    if (flag_any) begin
      show_io_d = io_seen_q;
      hold_d    = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else begin
      show_io_d = 1'b0;
    end
    bcd_digits_d = show_io_q ? io_bcd_q : pc_bcd_q;
    overflow_d   = show_io_q ? io_ovf_q : pc_ovf_q;
    neg_out_d    = show_io_q & io_neg_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      iter_q         <= '0;
      shift_q        <= '0;
      acc_q          <= '0;
      grant_io_q     <= 1'b0;
      last_grant_q   <= 1'b0;
      io_snap_q      <= '0;
      neg_snap_q     <= 1'b0;
      pc_snap_q      <= '0;
      io_seen_q      <= 1'b0;
      pc_seen_q      <= 1'b0;
      io_bcd_q       <= '0;
      io_ovf_q       <= 1'b0;
      io_neg_q       <= 1'b0;
      pc_bcd_q       <= '0;
      pc_ovf_q       <= 1'b0;
      result_valid_q <= 1'b0;
      hold_q         <= '0;
      show_io_q      <= 1'b0;
      bcd_digits_q   <= '0;
      overflow_q     <= 1'b0;
      neg_out_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      shift_q        <= shift_d;
      acc_q          <= acc_d;
      grant_io_q     <= grant_io_d;
      last_grant_q   <= last_grant_d;
      io_snap_q      <= io_snap_d;
      neg_snap_q     <= neg_snap_d;
      pc_snap_q      <= pc_snap_d;
      io_seen_q      <= io_seen_d;
      pc_seen_q      <= pc_seen_d;
      io_bcd_q       <= io_bcd_d;
      io_ovf_q       <= io_ovf_d;
      io_neg_q       <= io_neg_d;
      pc_bcd_q       <= pc_bcd_d;
      pc_ovf_q       <= pc_ovf_d;
      result_valid_q <= result_valid_d;
      hold_q         <= hold_d;
      show_io_q      <= show_io_d;
      bcd_digits_q   <= bcd_digits_d;
      overflow_q     <= overflow_d;
      neg_out_q      <= neg_out_d;
    end
  end

  assign bcd_digits   = bcd_digits_q;
  assign show_io      = show_io_q;
  assign neg_out      = neg_out_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Scoreboard bench for display_bcd_scheduler: directed stimulus pushes expected commits,
// a monitor pops them on each result_valid pulse and checks source and display outputs.
module tb_display_bcd_scheduler;

  logic        clock;
  logic        reset;
  logic [31:0] IO_output;
  logic        negative;
  logic [31:0] PC_current;
  logic        FLAG_input;
  logic        FLAG_output;
  logic [31:0] bcd_digits;
  logic        show_io;
  logic        neg_out;
  logic        overflow;
  logic        busy;
  logic        result_valid;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_io;
    bit          chk;
    logic [31:0] digits;
    bit          show;
    bit          ovf;
    bit          neg;
  } exp_t;

  exp_t sb_q[$];

  display_bcd_scheduler #(.HOLD_CYCLES(10), .HOLD_W(4)) dut (
    .clock(clock), .reset(reset),
    .IO_output(IO_output), .negative(negative), .PC_current(PC_current),
    .FLAG_input(FLAG_input), .FLAG_output(FLAG_output),
    .bcd_digits(bcd_digits), .show_io(show_io), .neg_out(neg_out),
    .overflow(overflow), .busy(busy), .result_valid(result_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] io, input logic neg,
                               input logic fin, input logic fout);
    @(negedge clock);
    PC_current  = pc;
    IO_output   = io;
    negative    = neg;
    FLAG_input  = fin;
    FLAG_output = fout;
  endtask

  task automatic pushExp(input bit is_io, input bit chk, input logic [31:0] d,
                         input bit s, input bit o, input bit n);
    exp_t e;
    e.is_io = is_io; e.chk = chk; e.digits = d; e.show = s; e.ovf = o; e.neg = n;
    sb_q.push_back(e);
  endtask

  task automatic waitDrain(input int bound);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < bound) begin
      @(negedge clock);
      i++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // Display outputs lag the commit: show_io one edge, bcd_digits a further edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && result_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: result_valid=1, expected no commit");
        end else begin
          e = sb_q[0];
          checkOutput("grant_src", {31'd0, dut.last_grant_q}, {31'd0, e.is_io});
          if (e.chk) begin
            repeat (2) @(negedge clock);
            checkOutput("bcd_digits", bcd_digits, e.digits);
            checkOutput("show_io", {31'd0, show_io}, {31'd0, e.show});
            checkOutput("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            checkOutput("neg_out", {31'd0, neg_out}, {31'd0, e.neg});
          end
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int seen;
    bit got_busy;
    reset = 1'b1;
    PC_current = 32'd1234; IO_output = '0; negative = 1'b0;
    FLAG_input = 1'b0; FLAG_output = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_bcd", bcd_digits, 32'h0);
    checkOutput("rst_show", {31'd0, show_io}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_neg", {31'd0, neg_out}, 32'd0);

    pushExp(1'b0, 1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    waitDrain(60);

    pushExp(1'b1, 1'b1, 32'h98765432, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'd1234, 32'd98765432, 1'b1, 1'b0, 1'b1);
    waitDrain(60);

    pushExp(1'b1, 1'b1, 32'h94967295, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'd1234, 32'd4294967295, 1'b0, 1'b0, 1'b1);
    waitDrain(60);

    // PC-only commit while the IO view is up must leave the display on IO.
    pushExp(1'b0, 1'b1, 32'h94967295, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'd5678, 32'd4294967295, 1'b0, 1'b0, 1'b1);
    waitDrain(60);

    // Both sources change every cycle: after the third commit the inputs freeze, leaving one
    // pending PC and then one pending IO conversion.
    pushExp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    pushExp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    pushExp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    pushExp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    pushExp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd100, 32'd1000, 1'b0, 1'b1, 1'b0);
    seen = 0;
    for (int c = 0; c < 400 && seen < 3; c++) begin
      @(negedge clock);
      if (result_valid) seen++;
      if (seen < 3) begin
        PC_current = PC_current + 32'd1;
        IO_output  = IO_output + 32'd7;
      end
    end
    waitDrain(120);

    pushExp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd20240607, IO_output, 1'b0, 1'b1, 1'b0);
    waitDrain(60);

    applyStimulus(32'd20240607, IO_output, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("hold_show", {31'd0, show_io}, 32'd1);
    end
    @(negedge clock);
    checkOutput("hold_expired", {31'd0, show_io}, 32'd0);
    @(negedge clock);
    checkOutput("pc_view_bcd", bcd_digits, 32'h20240607);
    checkOutput("pc_view_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("pc_view_neg", {31'd0, neg_out}, 32'd0);

    // Abort a PC conversion at iteration 15 and make sure nothing is committed.
    applyStimulus(32'd87654321, IO_output, 1'b0, 1'b0, 1'b0);
    got_busy = 1'b0;
    for (int i = 0; i < 10 && !got_busy; i++) begin
      @(negedge clock);
      if (busy) got_busy = 1'b1;
    end
    checkOutput("busy_rise", {31'd0, got_busy}, 32'd1);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("abort_bcd", bcd_digits, 32'h0);
    checkOutput("abort_show", {31'd0, show_io}, 32'd0);
    pushExp(1'b0, 1'b1, 32'h87654321, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    waitDrain(60);

    repeat (60) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
